muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 158 +++++++++++++++
 tb/tb_muldiv_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: 32-step shift-add multiply and restoring
// divide on operand magnitudes, with a final sign-fix cycle before hi/lo
// are written. hi/lo double as the MTHI/MTLO architectural registers.
module muldiv_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  MulDivOp,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        hiWrite,
   input  logic        loWrite,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        divByZero
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX
   } state_t;

   state_t      state_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [1:0]  op_q;
   logic [4:0]  cnt_q;
   logic [63:0] acc_q;
   logic [63:0] acc_d;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        done_q;
   logic        dz_q;

   // operand magnitudes (latched and incoming) and accumulator seed
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] in_mag_a;
   logic [31:0] in_mag_b;
   logic [63:0] acc_init;

   // step datapath intermediates
   logic [32:0] sum;
   logic [64:0] shl;
   logic [32:0] diff;

   // sign-fix results
   logic [63:0] prod_fix;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;
   logic [31:0] hi_d;
   logic [31:0] lo_d;
   logic        dz_d;

   // operand magnitudes: signed ops negate negative operands
   always_comb begin
      mag_a    = (op_q[0] && a_q[31]) ? -a_q : a_q;
      mag_b    = (op_q[0] && b_q[31]) ? -b_q : b_q;
      in_mag_a = (MulDivOp[0] && a[31]) ? -a : a;
      in_mag_b = (MulDivOp[0] && b[31]) ? -b : b;
      // multiply keeps the multiplier in the low half; divide keeps the dividend there
      acc_init = MulDivOp[1] ? {32'h0, in_mag_a} : {32'h0, in_mag_b};
   end

   // one radix-2 step: shift-add multiply or restoring divide on acc_q
   always_comb begin
      sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_a} : 33'h0);
      shl  = {acc_q, 1'b0};
      diff = shl[64:32] - {1'b0, mag_b};
      if (op_q[1]) begin
         // acc holds {remainder, quotient}; quotient bits shift in from the right
         if (!diff[32]) begin
            acc_d = {diff[31:0], shl[31:1], 1'b1};
         end else begin
            acc_d = shl[63:0];
         end
      end else begin
         // acc holds {partial product, remaining multiplier bits}
         acc_d = {sum, acc_q[31:1]};
      end
   end

   // sign correction and divide-by-zero override applied in FIX
   always_comb begin
      prod_fix = (op_q[0] && (a_q[31] ^ b_q[31])) ? -acc_q : acc_q;
      quo_fix  = (op_q[0] && (a_q[31] ^ b_q[31])) ? -acc_q[31:0] : acc_q[31:0];
      rem_fix  = (op_q[0] && a_q[31]) ? -acc_q[63:32] : acc_q[63:32];
      dz_d     = 1'b0;
      if (!op_q[1]) begin
         hi_d = prod_fix[63:32];
         lo_d = prod_fix[31:0];
      end else if (b_q == 32'h0) begin
         hi_d = a_q;
         lo_d = '1;
         dz_d = 1'b1;
      end else begin
         hi_d = rem_fix;
         lo_d = quo_fix;
      end
   end

   // control FSM plus all architectural state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  op_q    <= MulDivOp;
                  cnt_q   <= '0;
                  acc_q   <= acc_init;
                  dz_q    <= 1'b0;
                  state_q <= S_CALC;
               end else begin
                  if (hiWrite) hi_q <= a;
                  if (loWrite) lo_q <= a;
               end
            end
            S_CALC: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) state_q <= S_FIX;
            end
            S_FIX: begin
               hi_q    <= hi_d;
               lo_q    <= lo_d;
               dz_q    <= dz_d;
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign divByZero = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, randomized
// operations against an arithmetic reference model, and control corner cases.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  MulDivOp;
   logic [31:0] a;
   logic [31:0] b;
   logic        hiWrite;
   logic        loWrite;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        divByZero;

   int checks = 0;
   int errors = 0;

   muldiv_unit dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .MulDivOp  (MulDivOp),
      .a         (a),
      .b         (b),
      .hiWrite   (hiWrite),
      .loWrite   (loWrite),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo),
      .divByZero (divByZero)
   );

   always #5 clk = ~clk;

   // reference: plain 64-bit arithmetic on the architectural operation
   function automatic void model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] mhi, output logic [31:0] mlo, output logic mdz);
      longint      sx, sy, q, r;
      logic [63:0] p;
      sx  = $signed(x);
      sy  = $signed(y);
      mdz = 1'b0;
      mhi = '0;
      mlo = '0;
      case (op)
         2'd0: begin p = {32'h0, x} * {32'h0, y}; mhi = p[63:32]; mlo = p[31:0]; end
         2'd1: begin p = sx * sy; mhi = p[63:32]; mlo = p[31:0]; end
         default: begin
            if (y == 32'h0) begin
               mhi = x; mlo = 32'hFFFF_FFFF; mdz = 1'b1;
            end else if (op == 2'd2) begin
               mlo = x / y; mhi = x % y;
            end else begin
               q = sx / sy; r = sx % sy;
               mlo = q[31:0]; mhi = r[31:0];
            end
         end
      endcase
   endfunction

   // drives one operation and reports edges-to-done and busy cycles; inputs are scrambled while busy
   task automatic do_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int bcnt);
      @(negedge clk);
      MulDivOp = op; a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      bcnt  = busy ? 1 : 0;
      lat   = 0;
      while (lat < 40) begin
         a = $urandom; b = $urandom; MulDivOp = 2'($urandom_range(0, 3));
         @(posedge clk); #1;
         lat++;
         if (done) break;
         if (busy) bcnt++;
      end
   endtask

   task automatic test_reset();
      logic [31:0] eh, el;
      logic        ed;
      int          n;
      rst = 1'b1; start = 1'b0; hiWrite = 1'b0; loWrite = 1'b0;
      MulDivOp = 2'd0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
      checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b expected 0", done); end
      checks++; if (hi !== 32'h0)       begin errors++; $display("FAIL reset_hi got %h expected 0", hi); end
      checks++; if (lo !== 32'h0)       begin errors++; $display("FAIL reset_lo got %h expected 0", lo); end
      checks++; if (divByZero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b expected 0", divByZero); end
      // start on the first edge after reset releases
      rst = 1'b0; start = 1'b1; MulDivOp = 2'd0; a = 32'd9; b = 32'd11;
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL post_reset_start got busy=%b expected 1", busy); end
      n = 0;
      while (!done && n < 40) begin @(posedge clk); #1; n++; end
      model(2'd0, 32'd9, 32'd11, eh, el, ed);
      checks++; if (n !== 33) begin errors++; $display("FAIL post_reset_latency got %0d expected 33", n); end
      checks++; if (lo !== el) begin errors++; $display("FAIL post_reset_lo got %h expected %h", lo, el); end
   endtask

   task automatic test_directed();
      logic [1:0]  t_op [8] = '{2'd0, 2'd1, 2'd3, 2'd3, 2'd2, 2'd0, 2'd3, 2'd1};
      logic [31:0] t_a  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'h80000000,
                                32'h00000064, 32'h00000003, 32'hFFFFFFF9, 32'h7FFFFFFF};
      logic [31:0] t_b  [8] = '{32'hFFFFFFFF, 32'h00000007, 32'h00000002, 32'hFFFFFFFF,
                                32'h00000000, 32'h00000004, 32'h00000000, 32'h80000000};
      logic [31:0] t_hi [8] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000,
                                32'h00000064, 32'h00000000, 32'hFFFFFFF9, 32'hC0000000};
      logic [31:0] t_lo [8] = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'h80000000,
                                32'hFFFFFFFF, 32'h0000000C, 32'hFFFFFFFF, 32'h80000000};
      logic        t_dz [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      int lat, bcnt;
      for (int i = 0; i < 8; i++) begin
         do_op(t_op[i], t_a[i], t_b[i], lat, bcnt);
         checks++; if (lat !== 33)        begin errors++; $display("FAIL dir%0d_latency got %0d expected 33", i, lat); end
         checks++; if (bcnt !== 33)       begin errors++; $display("FAIL dir%0d_busy_cycles got %0d expected 33", i, bcnt); end
         checks++; if (hi !== t_hi[i])    begin errors++; $display("FAIL dir%0d_hi got %h expected %h", i, hi, t_hi[i]); end
         checks++; if (lo !== t_lo[i])    begin errors++; $display("FAIL dir%0d_lo got %h expected %h", i, lo, t_lo[i]); end
         checks++; if (divByZero !== t_dz[i]) begin errors++; $display("FAIL dir%0d_dz got %b expected %b", i, divByZero, t_dz[i]); end
      end
   endtask

   task automatic test_random();
      logic [1:0]  op;
      logic [31:0] x, y, eh, el;
      logic        ed;
      int          lat, bcnt, sel;
      for (int i = 0; i < 60; i++) begin
         op  = 2'($urandom_range(0, 3));
         x   = $urandom;
         y   = $urandom;
         sel = $urandom_range(0, 7);
         case (sel)
            0: y = 32'h0;
            1: x = 32'h8000_0000;
            2: y = 32'hFFFF_FFFF;
            3: begin x = 32'($urandom_range(0, 20)); y = 32'($urandom_range(1, 5)); end
            4: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            default: ;
         endcase
         model(op, x, y, eh, el, ed);
         do_op(op, x, y, lat, bcnt);
         checks++; if (lat !== 33) begin errors++; $display("FAIL rnd%0d_latency op=%0d got %0d expected 33", i, op, lat); end
         checks++; if (hi !== eh)  begin errors++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got %h expected %h", i, op, x, y, hi, eh); end
         checks++; if (lo !== el)  begin errors++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got %h expected %h", i, op, x, y, lo, el); end
         checks++; if (divByZero !== ed) begin errors++; $display("FAIL rnd%0d_dz op=%0d got %b expected %b", i, op, divByZero, ed); end
      end
   endtask

   task automatic test_mthi_mtlo();
      logic [31:0] v1, v2, v3, v4, v5, eh, el;
      logic        ed;
      int          n;
      v1 = $urandom; v2 = $urandom; v3 = $urandom; v4 = $urandom; v5 = $urandom;
      @(negedge clk); a = v1; hiWrite = 1'b1; loWrite = 1'b1;
      @(negedge clk); a = v2; hiWrite = 1'b1; loWrite = 1'b0;
      @(posedge clk); #1;
      checks++; if (hi !== v2) begin errors++; $display("FAIL mthi_hi got %h expected %h", hi, v2); end
      checks++; if (lo !== v1) begin errors++; $display("FAIL mthi_lo_kept got %h expected %h", lo, v1); end
      @(negedge clk); a = v3; hiWrite = 1'b0; loWrite = 1'b1;
      @(posedge clk); #1;
      checks++; if (lo !== v3) begin errors++; $display("FAIL mtlo_lo got %h expected %h", lo, v3); end
      checks++; if (hi !== v2) begin errors++; $display("FAIL mtlo_hi_kept got %h expected %h", hi, v2); end
      // start together with both writes: the writes are dropped
      @(negedge clk); a = v4; b = v5; MulDivOp = 2'd0; start = 1'b1; hiWrite = 1'b1; loWrite = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; hiWrite = 1'b0; loWrite = 1'b0;
      checks++; if (hi !== v2 || lo !== v3) begin errors++; $display("FAIL start_wins got %h_%h expected %h_%h", hi, lo, v2, v3); end
      n = 0;
      while (!done && n < 40) begin @(posedge clk); #1; n++; end
      model(2'd0, v4, v5, eh, el, ed);
      checks++; if (n !== 33) begin errors++; $display("FAIL start_wins_latency got %0d expected 33", n); end
      checks++; if (hi !== eh || lo !== el) begin errors++; $display("FAIL start_wins_result got %h_%h expected %h_%h", hi, lo, eh, el); end
   endtask

   task automatic test_isolation();
      int dones, done_at, hold_err;
      @(negedge clk); a = 32'h1234_5678; hiWrite = 1'b1; loWrite = 1'b1;
      @(negedge clk); hiWrite = 1'b0; loWrite = 1'b0;
      MulDivOp = 2'd0; a = 32'd5; b = 32'd6; start = 1'b1;
      @(posedge clk); #1;
      dones = 0; done_at = -1; hold_err = 0;
      for (int c = 1; c <= 45; c++) begin
         if (c <= 30) begin
            a = $urandom; b = $urandom; MulDivOp = 2'($urandom_range(0, 3));
            start = c[0]; hiWrite = (c == 10); loWrite = (c == 12);
         end else begin
            start = 1'b0; hiWrite = 1'b0; loWrite = 1'b0;
         end
         @(posedge clk); #1;
         if (done) begin dones++; if (done_at < 0) done_at = c; end
         if (c < 33 && (hi !== 32'h1234_5678 || lo !== 32'h1234_5678)) hold_err++;
      end
      checks++; if (dones !== 1)      begin errors++; $display("FAIL iso_done_count got %0d expected 1", dones); end
      checks++; if (done_at !== 33)   begin errors++; $display("FAIL iso_done_edge got %0d expected 33", done_at); end
      checks++; if (hold_err !== 0)   begin errors++; $display("FAIL iso_hilo_hold got %0d bad cycles expected 0", hold_err); end
      checks++; if (hi !== 32'h0)     begin errors++; $display("FAIL iso_hi got %h expected 0", hi); end
      checks++; if (lo !== 32'd30)    begin errors++; $display("FAIL iso_lo got %h expected 1e", lo); end
   endtask

   task automatic test_abort();
      logic [31:0] x, y, eh, el;
      logic        ed;
      int          n, dones;
      @(negedge clk); a = 32'hDEAD_BEEF; hiWrite = 1'b1; loWrite = 1'b1;
      @(negedge clk); hiWrite = 1'b0; loWrite = 1'b0;
      MulDivOp = 2'd1; a = $urandom; b = $urandom; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; dones = 0;
      for (int c = 1; c <= 9; c++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b expected 0", busy); end
      checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL abort_hilo got %h_%h expected 0_0", hi, lo); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b expected 0", done); end
      rst = 1'b0;
      x = $urandom; y = $urandom;
      MulDivOp = 2'd2; a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; n = 0;
      while (n < 40) begin
         @(posedge clk); #1;
         n++;
         if (done) begin dones++; break; end
      end
      model(2'd2, x, y, eh, el, ed);
      checks++; if (n !== 33)    begin errors++; $display("FAIL abort_restart_latency got %0d expected 33", n); end
      checks++; if (dones !== 1) begin errors++; $display("FAIL abort_done_count got %0d expected 1", dones); end
      checks++; if (hi !== eh || lo !== el) begin errors++; $display("FAIL abort_restart_result got %h_%h expected %h_%h", hi, lo, eh, el); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] x, y, eh, el;
      logic        ed;
      int          done_edges[$];
      int          bad_res;
      x = $urandom; y = $urandom_range(1, 1000);
      model(2'd3, x, y, eh, el, ed);
      bad_res = 0;
      @(negedge clk); MulDivOp = 2'd3; a = x; b = y; start = 1'b1;
      for (int c = 0; c <= 75; c++) begin
         @(posedge clk); #1;
         if (c == 40) start = 1'b0;
         if (done) begin
            done_edges.push_back(c);
            if (hi !== eh || lo !== el) bad_res++;
         end
      end
      checks++; if (done_edges.size() !== 2) begin errors++; $display("FAIL b2b_done_count got %0d expected 2", done_edges.size()); end
      if (done_edges.size() >= 2) begin
         checks++; if (done_edges[0] !== 33) begin errors++; $display("FAIL b2b_first_done got %0d expected 33", done_edges[0]); end
         checks++; if (done_edges[1] !== 67) begin errors++; $display("FAIL b2b_second_done got %0d expected 67", done_edges[1]); end
      end
      checks++; if (bad_res !== 0) begin errors++; $display("FAIL b2b_results got %0d wrong expected 0", bad_res); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_mthi_mtlo();
      test_isolation();
      test_abort();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
